datapath_sequencer: RTL and testbench

Multi-cycle sequencer for the 64-bit register-file / ALU / data-memory datapath.
- Accepts one 32-bit instruction at a time over a valid/ready handshake.
- Steps it through DECODE, EXEC, MEM and WB states, driving register-file addresses and enables, ALU operation and operand select, and data-memory strobes.
- Sits between the instruction source (bench or fetch logic) and the datapath. Replaces purely combinational decode when memory has wait states.

---
 rtl/datapath_sequencer_if.sv | 36 +++
 rtl/datapath_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_datapath_sequencer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/datapath_sequencer_if.sv
// Instruction handshake and datapath control bundle for datapath_sequencer.
// master = instruction source / datapath side, slave = the sequencer.
interface datapath_sequencer_if #(
  parameter int WORDSIZE = 64,
  parameter int SIZE     = 32
);
  logic                instr_valid;
  logic [SIZE-1:0]     instruction;
  logic                instr_ready;
  logic [4:0]          rf_addr_a;
  logic [4:0]          rf_addr_b;
  logic [4:0]          rf_write_addr;
  logic                rf_write_enable;
  logic                alu_op;
  logic                alu_src_imm;
  logic [WORDSIZE-1:0] imm;
  logic                dm_read;
  logic                dm_write_enable;
  logic                wb_src_mem;
  logic                done;
  logic                illegal;

  modport master (
    output instr_valid, instruction,
    input  instr_ready, rf_addr_a, rf_addr_b, rf_write_addr, rf_write_enable,
           alu_op, alu_src_imm, imm, dm_read, dm_write_enable, wb_src_mem,
           done, illegal
  );

  modport slave (
    input  instr_valid, instruction,
    output instr_ready, rf_addr_a, rf_addr_b, rf_write_addr, rf_write_enable,
           alu_op, alu_src_imm, imm, dm_read, dm_write_enable, wb_src_mem,
           done, illegal
  );
endinterface

// File: rtl/datapath_sequencer.sv
// Multi-cycle DECODE/EXEC/MEM/WB sequencer for the 64-bit RF/ALU/DM datapath.
// Optional retire/illegal counters are built when SEQ_RETIRE_COUNT_EN is defined.
module datapath_sequencer #(
  parameter int WORDSIZE = 64,
  parameter int SIZE     = 32,
  parameter int MEM_WAIT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  datapath_sequencer_if.slave   bus
`ifdef SEQ_RETIRE_COUNT_EN
  ,
  output logic [31:0]           retired_count,
  output logic [15:0]           illegal_count
`endif
);

  typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB} state_e;
  typedef enum logic [2:0] {K_ADD, K_SUB, K_ADDI, K_LD, K_SD, K_ILL} kind_e;

  typedef struct packed {
    logic instr_ready;
    logic rf_write_enable;
    logic alu_op;
    logic alu_src_imm;
    logic dm_read;
    logic dm_write_enable;
    logic wb_src_mem;
    logic done;
    logic illegal;
  } ctrl_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [3:0] MEM_WAIT_C = 4'(MEM_WAIT);

  function automatic kind_e kind_of(input logic [SIZE-1:0] ins);
    kind_e k;
    k = K_ILL;
    case (ins[6:0])
      OP_R: begin
        if (ins[14:12] == 3'b000 && ins[31:25] == 7'h00) k = K_ADD;
        else if (ins[14:12] == 3'b000 && ins[31:25] == 7'h20) k = K_SUB;
        else k = K_ILL;
      end
      OP_ADDI: k = (ins[14:12] == 3'b000) ? K_ADDI : K_ILL;
      OP_LD:   k = (ins[14:12] == 3'b011) ? K_LD : K_ILL;
      OP_SD:   k = (ins[14:12] == 3'b011) ? K_SD : K_ILL;
      default: k = K_ILL;
    endcase
    return k;
  endfunction

  function automatic logic [WORDSIZE-1:0] imm_of(input logic [SIZE-1:0] ins);
    logic [11:0] raw;
    raw = 12'h000;
    case (kind_of(ins))
      K_ADDI, K_LD: raw = ins[31:20];
      K_SD:         raw = {ins[31:25], ins[11:7]};
      default:      raw = 12'h000;
    endcase
    return {{(WORDSIZE-12){raw[11]}}, raw};
  endfunction

  // Control levels for the cycle spent in state st; cnt is the wait count held in that cycle.
  function automatic ctrl_t ctrl_of(input state_e st, input kind_e k,
                                    input logic [3:0] cnt, input logic [4:0] rd);
    ctrl_t c;
    c = '0;
    case (st)
      IDLE:   c.instr_ready = 1'b1;
      DECODE: c.illegal = (k == K_ILL);
      EXEC: begin
        c.alu_op      = (k == K_SUB);
        c.alu_src_imm = (k == K_ADDI) || (k == K_LD) || (k == K_SD);
      end
      MEM: begin
        c.alu_src_imm     = 1'b1;
        c.dm_read         = (k == K_LD);
        c.dm_write_enable = (k == K_SD);
        c.done            = (k == K_SD) && (cnt == 4'd0);
      end
      WB: begin
        c.rf_write_enable = (rd != 5'd0);
        c.wb_src_mem      = (k == K_LD);
        c.done            = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_e              state_r;
  logic [SIZE-1:0]     ir_r;
  logic [WORDSIZE-1:0] imm_r;
  logic [3:0]          cnt_r;
  ctrl_t               ctrl_r;
  kind_e               kind_s;
  logic [4:0]          rd_s;

  assign kind_s = kind_of(ir_r);
  assign rd_s   = ir_r[11:7];

  // Sequencer FSM; control outputs are registered for the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      ir_r    <= '0;
      imm_r   <= '0;
      cnt_r   <= 4'd0;
      ctrl_r  <= ctrl_of(IDLE, K_ILL, 4'd0, 5'd0);
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.instr_valid) begin
            ir_r    <= bus.instruction;
            imm_r   <= imm_of(bus.instruction);
            state_r <= DECODE;
            ctrl_r  <= ctrl_of(DECODE, kind_of(bus.instruction), cnt_r, bus.instruction[11:7]);
          end else begin
            ctrl_r  <= ctrl_of(IDLE, kind_s, cnt_r, rd_s);
          end
        end
        DECODE: begin
          if (kind_s == K_ILL) begin
            state_r <= IDLE;
            ctrl_r  <= ctrl_of(IDLE, kind_s, cnt_r, rd_s);
          end else begin
            state_r <= EXEC;
            ctrl_r  <= ctrl_of(EXEC, kind_s, cnt_r, rd_s);
          end
        end
        EXEC: begin
          if (kind_s == K_LD || kind_s == K_SD) begin
            state_r <= MEM;
            cnt_r   <= MEM_WAIT_C;
            ctrl_r  <= ctrl_of(MEM, kind_s, MEM_WAIT_C, rd_s);
          end else begin
            state_r <= WB;
            ctrl_r  <= ctrl_of(WB, kind_s, cnt_r, rd_s);
          end
        end
        MEM: begin
          if (cnt_r != 4'd0) begin
            cnt_r  <= cnt_r - 4'd1;
            ctrl_r <= ctrl_of(MEM, kind_s, cnt_r - 4'd1, rd_s);
          end else if (kind_s == K_LD) begin
            state_r <= WB;
            ctrl_r  <= ctrl_of(WB, kind_s, cnt_r, rd_s);
          end else begin
            state_r <= IDLE;
            ctrl_r  <= ctrl_of(IDLE, kind_s, cnt_r, rd_s);
          end
        end
        WB: begin
          state_r <= IDLE;
          ctrl_r  <= ctrl_of(IDLE, kind_s, cnt_r, rd_s);
        end
        default: begin
          state_r <= IDLE;
          ctrl_r  <= ctrl_of(IDLE, K_ILL, 4'd0, 5'd0);
        end
      endcase
    end
  end

  assign bus.instr_ready     = ctrl_r.instr_ready;
  assign bus.rf_addr_a       = ir_r[19:15];
  assign bus.rf_addr_b       = ir_r[24:20];
  assign bus.rf_write_addr   = ir_r[11:7];
  assign bus.rf_write_enable = ctrl_r.rf_write_enable;
  assign bus.alu_op          = ctrl_r.alu_op;
  assign bus.alu_src_imm     = ctrl_r.alu_src_imm;
  assign bus.imm             = imm_r;
  assign bus.dm_read         = ctrl_r.dm_read;
  assign bus.dm_write_enable = ctrl_r.dm_write_enable;
  assign bus.wb_src_mem      = ctrl_r.wb_src_mem;
  assign bus.done            = ctrl_r.done;
  assign bus.illegal         = ctrl_r.illegal;

`ifdef SEQ_RETIRE_COUNT_EN
  // Retire counter wraps; illegal counter saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_count <= 32'd0;
      illegal_count <= 16'd0;
    end else begin
      if (ctrl_r.done) retired_count <= retired_count + 32'd1;
      else retired_count <= retired_count;
      if (ctrl_r.illegal && illegal_count != 16'hFFFF) illegal_count <= illegal_count + 16'd1;
      else illegal_count <= illegal_count;
    end
  end
`endif

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: two instances (MEM_WAIT 0 and 2) checked every cycle
// against a per-instruction timeline model, plus hand-computed spot checks.
module tb_datapath_sequencer;

  typedef struct packed {
    logic        ready;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [4:0]  wr;
    logic        we;
    logic        aluop;
    logic        srcimm;
    logic [63:0] imm;
    logic        dmr;
    logic        dmw;
    logic        wbm;
    logic        done;
    logic        ill;
  } obs_t;

  typedef struct {
    int          lat;
    int          rd_cnt;
    int          wr_cnt;
    int          we_cnt;
    bit          done_seen;
    bit          ill_seen;
    bit          dmw_at_done;
    bit          wbm_at_done;
    bit          ready_after;
    bit          timeout;
    logic [63:0] imm;
    logic [4:0]  a;
    logic [4:0]  b;
    logic [4:0]  wr;
    bit          aluop;
    bit          srcimm;
  } res_t;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_LD   = 32'h0080B283;
  localparam logic [31:0] I_SD   = 32'h0050B823;
  localparam logic [31:0] I_ADDM = 32'hFFF00013;
  localparam logic [31:0] I_ADD5 = 32'h00500293;
  localparam logic [31:0] I_MUL  = 32'h022081B3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   chk_en = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  datapath_sequencer_if #(.WORDSIZE(64), .SIZE(32)) bus0 ();
  datapath_sequencer_if #(.WORDSIZE(64), .SIZE(32)) bus2 ();

`ifdef SEQ_RETIRE_COUNT_EN
  logic [31:0] rc0, rc2;
  logic [15:0] ic0, ic2;
`endif

  datapath_sequencer #(.WORDSIZE(64), .SIZE(32), .MEM_WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
`ifdef SEQ_RETIRE_COUNT_EN
    , .retired_count(rc0), .illegal_count(ic0)
`endif
  );

  datapath_sequencer #(.WORDSIZE(64), .SIZE(32), .MEM_WAIT(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
`ifdef SEQ_RETIRE_COUNT_EN
    , .retired_count(rc2), .illegal_count(ic2)
`endif
  );

  obs_t obs [2];
  always_comb begin
    obs[0] = {bus0.instr_ready, bus0.rf_addr_a, bus0.rf_addr_b, bus0.rf_write_addr,
              bus0.rf_write_enable, bus0.alu_op, bus0.alu_src_imm, bus0.imm, bus0.dm_read,
              bus0.dm_write_enable, bus0.wb_src_mem, bus0.done, bus0.illegal};
    obs[1] = {bus2.instr_ready, bus2.rf_addr_a, bus2.rf_addr_b, bus2.rf_write_addr,
              bus2.rf_write_enable, bus2.alu_op, bus2.alu_src_imm, bus2.imm, bus2.dm_read,
              bus2.dm_write_enable, bus2.wb_src_mem, bus2.done, bus2.illegal};
  end

  // ---------------- reference model ----------------
  // 0 add, 1 sub, 2 addi, 3 ld, 4 sd, 5 illegal
  function automatic int cls(input logic [31:0] ins);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    if (op == 7'b0110011 && f3 == 3'd0 && f7 == 7'h00) return 0;
    if (op == 7'b0110011 && f3 == 3'd0 && f7 == 7'h20) return 1;
    if (op == 7'b0010011 && f3 == 3'd0) return 2;
    if (op == 7'b0000011 && f3 == 3'd3) return 3;
    if (op == 7'b0100011 && f3 == 3'd3) return 4;
    return 5;
  endfunction

  function automatic int mw_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  // Index of the retiring (or illegal) cycle, counting DECODE as 0.
  function automatic int last_k(input logic [31:0] ins, input int mw);
    case (cls(ins))
      0, 1, 2: return 2;
      3:       return 3 + mw;
      4:       return 2 + mw;
      default: return 0;
    endcase
  endfunction

  function automatic obs_t model_out(input logic [31:0] ins, input int mw, input int k);
    obs_t o;
    int   c;
    c = cls(ins);
    o = '0;
    o.a  = ins[19:15];
    o.b  = ins[24:20];
    o.wr = ins[11:7];
    if (c == 2 || c == 3) o.imm = 64'($signed(ins[31:20]));
    else if (c == 4) o.imm = 64'($signed({ins[31:25], ins[11:7]}));
    else o.imm = 64'd0;
    if (k == 0) begin
      o.ill = (c == 5);
    end else if (k == 1) begin
      o.aluop  = (c == 1);
      o.srcimm = (c >= 2 && c <= 4);
    end else if ((c == 3 || c == 4) && k <= 2 + mw) begin
      o.srcimm = 1'b1;
      o.dmr    = (c == 3);
      o.dmw    = (c == 4);
      o.done   = (c == 4) && (k == 2 + mw);
    end else begin
      o.we   = (ins[11:7] != 5'd0);
      o.wbm  = (c == 3);
      o.done = 1'b1;
    end
    return o;
  endfunction

  function automatic logic vin(input int d);
    return (d == 0) ? bus0.instr_valid : bus2.instr_valid;
  endfunction

  function automatic logic [31:0] iin(input int d);
    return (d == 0) ? bus0.instruction : bus2.instruction;
  endfunction

  bit          m_act [2];
  int          m_k   [2];
  logic [31:0] m_ins [2];

  // Model timeline: start on handshake, advance one step per clock, drop on reset.
  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_act[d] <= 1'b0;
      end else if (m_act[d]) begin
        if (m_k[d] == last_k(m_ins[d], mw_of(d))) m_act[d] <= 1'b0;
        else m_k[d] <= m_k[d] + 1;
      end else if (vin(d)) begin
        m_act[d] <= 1'b1;
        m_k[d]   <= 0;
        m_ins[d] <= iin(d);
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        obs_t e, m;
        if (m_act[d]) begin
          e = model_out(m_ins[d], mw_of(d), m_k[d]);
          m = '1;
        end else begin
          e = '0;
          e.ready = 1'b1;
          m = '0;
          m.ready = 1'b1; m.we = 1'b1; m.aluop = 1'b1; m.srcimm = 1'b1; m.dmr = 1'b1;
          m.dmw = 1'b1; m.wbm = 1'b1; m.done = 1'b1; m.ill = 1'b1;
        end
        n_cmp++;
        if ((obs[d] & m) !== (e & m)) begin
          n_bad++;
          $display("FAIL cycle_dut%0d t=%0t got %h expected %h (mask %h)",
                   d, $time, obs[d], e, m);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input int d, input logic v, input logic [31:0] ins);
    if (d == 0) begin
      bus0.instr_valid = v;
      bus0.instruction = ins;
    end else begin
      bus2.instr_valid = v;
      bus2.instruction = ins;
    end
  endtask

  task automatic run(input int d, input logic [31:0] ins, output res_t r);
    obs_t o;
    r.lat = 0; r.rd_cnt = 0; r.wr_cnt = 0; r.we_cnt = 0; r.done_seen = 0; r.ill_seen = 0;
    r.dmw_at_done = 0; r.wbm_at_done = 0; r.ready_after = 0; r.timeout = 0;
    r.imm = '0; r.a = '0; r.b = '0; r.wr = '0; r.aluop = 0; r.srcimm = 0;
    @(negedge clk);
    set_in(d, 1'b1, ins);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) set_in(d, 1'b0, ~ins);
      o = obs[d];
      if (cyc == 1) begin r.imm = o.imm; r.a = o.a; r.b = o.b; r.wr = o.wr; end
      if (cyc == 2) begin r.aluop = o.aluop; r.srcimm = o.srcimm; end
      if (o.dmr) r.rd_cnt++;
      if (o.dmw) r.wr_cnt++;
      if (o.we)  r.we_cnt++;
      if (o.done || o.ill) begin
        r.lat = cyc; r.done_seen = o.done; r.ill_seen = o.ill;
        r.dmw_at_done = o.dmw; r.wbm_at_done = o.wbm;
        break;
      end
    end
    if (r.lat == 0) begin
      r.timeout = 1;
    end else begin
      @(negedge clk);
      r.ready_after = obs[d].ready;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    res_t r;
    obs_t rst_exp;
    int   nd, first, lastd, gap_bad;
    bit   found;
    set_in(0, 1'b0, 32'd0);
    set_in(1, 1'b0, 32'd0);
    rst_exp = '0;
    rst_exp.ready = 1'b1;

    #7 rst = 1'b1;
    #1;
    chk("reset_dut0", obs[0], rst_exp);
    chk("reset_dut2", obs[1], rst_exp);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    run(0, I_ADD, r);
    chk("add_timeout", r.timeout, 0);
    chk("add_lat", r.lat, 3);
    chk("add_a", r.a, 1);
    chk("add_b", r.b, 2);
    chk("add_wr", r.wr, 3);
    chk("add_aluop", r.aluop, 0);
    chk("add_srcimm", r.srcimm, 0);
    chk("add_we", r.we_cnt, 1);
    chk("add_done", r.done_seen, 1);

    run(0, I_SUB, r);
    chk("sub_aluop", r.aluop, 1);
    chk("sub_lat", r.lat, 3);

    run(1, I_LD, r);
    chk("ld_imm", r.imm, 64'd8);
    chk("ld_srcimm", r.srcimm, 1);
    chk("ld_dmread_cycles", r.rd_cnt, 3);
    chk("ld_wbmem", r.wbm_at_done, 1);
    chk("ld_we", r.we_cnt, 1);
    chk("ld_wr", r.wr, 5);
    chk("ld_lat", r.lat, 6);

    run(0, I_SD, r);
    chk("sd_imm", r.imm, 64'd16);
    chk("sd_dmwe_cycles", r.wr_cnt, 1);
    chk("sd_dmwe_at_done", r.dmw_at_done, 1);
    chk("sd_we", r.we_cnt, 0);
    chk("sd_ready_after", r.ready_after, 1);
    chk("sd_lat", r.lat, 3);

    run(0, I_ADDM, r);
    chk("addi_m1_imm", r.imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_m1_done", r.done_seen, 1);
    chk("addi_m1_we", r.we_cnt, 0);

    run(0, 32'h0000_0000, r);
    chk("ill_pulse", r.ill_seen, 1);
    chk("ill_done", r.done_seen, 0);
    chk("ill_lat", r.lat, 1);
    chk("ill_ready_after", r.ready_after, 1);

    run(1, I_SD, r);
    chk("sd_w2_lat", r.lat, 5);
    chk("sd_w2_dmwe_cycles", r.wr_cnt, 3);

    run(1, I_ADD5, r);
    chk("addi5_imm", r.imm, 64'd5);
    chk("addi5_we", r.we_cnt, 1);

    run(0, I_MUL, r);
    chk("mul_illegal", r.ill_seen, 1);

    // valid held high: one ADD per four cycles
    nd = 0; first = 0; lastd = 0; gap_bad = 0;
    @(negedge clk);
    set_in(0, 1'b1, I_ADD);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (cyc == 12) set_in(0, 1'b0, 32'd0);
      if (obs[0].done) begin
        nd++;
        if (first == 0) first = cyc;
        else if (cyc - lastd != 4) gap_bad++;
        lastd = cyc;
      end
    end
    chk("b2b_dones", nd, 3);
    chk("b2b_first", first, 3);
    chk("b2b_gap", gap_bad, 0);

    // reset in the middle of an LD memory access
    found = 0;
    @(negedge clk);
    set_in(1, 1'b1, I_LD);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (cyc == 1) set_in(1, 1'b0, 32'd0);
      if (obs[1].dmr) begin found = 1; break; end
    end
    chk("rst_ld_reached_mem", found, 1);
    #3 rst = 1'b1;
    #1;
    chk("rst_ld_dmread", obs[1].dmr, 0);
    chk("rst_ld_ready", obs[1].ready, 1);
    chk("rst_ld_done", obs[1].done, 0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      if (obs[1].done) nd++;
    end
    chk("rst_ld_no_done", nd, 0);
    run(1, I_ADD, r);
    chk("post_rst_add_lat", r.lat, 3);
    chk("post_rst_add_done", r.done_seen, 1);

`ifdef SEQ_RETIRE_COUNT_EN
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("cnt_reset_retired", rc2, 0);
    run(1, I_ADD, r);
    run(1, I_LD, r);
    run(1, 32'h0000_0000, r);
    chk("cnt_retired", rc2, 2);
    chk("cnt_illegal", ic2, 1);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
